gcd_rr_sched: RTL

- Round-robin scheduler that shares one GCD datapath unit (CLK/RST_N/A/B/START → Y/DONE/ERROR) between N_REQ requesters.
- Picks one pending request, loads its operands and pulses START.
- Waits for DONE, or for a timeout, then returns Y/ERROR to the owning requester with a one-cycle response strobe.
- Sits between client logic and the single GCD instance at the next level up.

---
 rtl/gcd_pkg.sv | 25 ++
 rtl/gcd_rr_pick.sv | 26 ++
 rtl/gcd_rr_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the round-robin GCD scheduler.
package gcd_pkg;

    localparam int DW_DEF      = 8;
    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 255;
    localparam int IDX_W_DEF   = $clog2(N_REQ_DEF);
    localparam int CNT_W_DEF   = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/gcd_rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping.
module gcd_rr_pick
    import gcd_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            if (req[IDX_W'((int'(ptr) + off) % N_REQ)]) begin
                gnt_idx = IDX_W'((int'(ptr) + off) % N_REQ);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_rr_sched.sv
// Shares one GCD unit among N_REQ requesters with round-robin grant and a
// per-job timeout; every output is registered.
//
// state    | meaning
// ST_IDLE  | arbitrate pending requests, latch owner and operands
// ST_ISSUE | GCD_START pulse, clear timeout counter
// ST_WAIT  | wait for GCD_DONE or timeout, capture response
// ST_RESP  | one-cycle RSP_VALID strobe to the owner
module gcd_rr_sched
    import gcd_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [N_REQ-1:0]    REQ,
    input  logic [N_REQ*DW-1:0] REQ_A,
    input  logic [N_REQ*DW-1:0] REQ_B,
    output logic [N_REQ-1:0]    RSP_VALID,
    output logic [DW-1:0]       RSP_Y,
    output logic                RSP_ERR,
    output logic                RSP_TO,
    output logic                BUSY,
    output logic                GCD_START,
    output logic [DW-1:0]       GCD_A,
    output logic [DW-1:0]       GCD_B,
    input  logic [DW-1:0]       GCD_Y,
    input  logic                GCD_DONE,
    input  logic                GCD_ERROR
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int CNT_W = cnt_w(TIMEOUT);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     gcd_a_q, gcd_a_d;
    logic [DW-1:0]     gcd_b_q, gcd_b_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_y_q, rsp_y_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_to_q, rsp_to_d;

    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [DW-1:0]     sel_a, sel_b;

    gcd_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (REQ),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_a = REQ_A[DW*i +: DW];
                sel_b = REQ_B[DW*i +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gcd_a_d     = gcd_a_q;
        gcd_b_d     = gcd_b_q;
        start_d     = 1'b0;
        rsp_valid_d = '0;
        rsp_y_d     = '0;
        rsp_err_d   = 1'b0;
        rsp_to_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_idx;
                    ptr_d   = gnt_idx;
                    gcd_a_d = sel_a;
                    gcd_b_d = sel_b;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // DONE takes precedence over a timeout landing in the same cycle
                if (GCD_DONE) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_y_d   = GCD_Y;
                    rsp_err_d = GCD_ERROR;
                    state_d   = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d = 1'b1;
                    rsp_to_d  = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_RST;
            owner_q     <= '0;
            cnt_q       <= '0;
            gcd_a_q     <= '0;
            gcd_b_q     <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gcd_a_q     <= gcd_a_d;
            gcd_b_q     <= gcd_b_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_Y     = rsp_y_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_TO    = rsp_to_q;
    assign BUSY      = busy_q;
    assign GCD_START = start_q;
    assign GCD_A     = gcd_a_q;
    assign GCD_B     = gcd_b_q;

endmodule
